// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, branch/jump redirect and the IF/ID pipeline register.
// Priority at each edge is reset, then redirect, then stall, then instruction-memory wait.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] ex_pc4,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc4;
    logic        br_taken;
    logic        redirect;
    logic [31:0] branch_sum;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;

    assign pc4           = pc_q + 32'd4;
    assign br_taken      = branch & zero;
    assign redirect      = br_taken | jump;
    assign branch_sum    = ex_pc4 + {branch_offset[29:0], 2'b00};
    // Low bits forced to zero so the PC stays word aligned whatever ex_pc4 holds.
    assign branch_target = {branch_sum[31:2], 2'b00};
    assign jump_target   = {ex_pc4[31:28], jump_index, 2'b00};
    assign target        = jump ? jump_target : branch_target;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (redirect) begin
            pc_d    = target;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (!imem_ready) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end else begin
                instr_d = imem_rdata;
                pc4_d   = pc4;
                valid_d = 1'b1;
                pc_d    = pc4;
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= ResetPcAligned;
            instr_q <= NOP_INSTR;
            pc4_q   <= ResetPcAligned + 32'd4;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = count_q;
    assign opcode      = valid_q ? instr_q[31:26] : NOP_INSTR[31:26];

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word presented in IF/ID when the register is invalid.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard hold; freezes PC and IF/ID.
REQ-006 branch  input  1  branch control bit of the resolving instruction.
REQ-007 zero  input  1  ALU zero flag of the resolving instruction.
REQ-008 jump  input  1  jump control bit of the resolving instruction.
REQ-009 ex_pc4  input  32  PC+4 of the resolving instruction.
REQ-010 branch_offset  input  32  sign-extended immediate, in words.
REQ-011 jump_index  input  26  instruction[25:0] of the resolving jump.
REQ-012 imem_addr  output  32  instruction memory address; equals the current PC.
REQ-013 imem_rdata  input  32  instruction word at imem_addr, valid when imem_ready=1.
REQ-014 imem_ready  input  1  instruction memory data-valid handshake.
REQ-015 if_id_instr  output  32  registered instruction word.
REQ-016 if_id_pc4  output  32  registered PC+4 of if_id_instr.
REQ-017 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-018 opcode  output  6  if_id_instr[31:26], combinational; feeds the main control decoder.
REQ-019 fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-020 Derived terms: pc4 = PC + 4; br_taken = branch & zero; redirect = br_taken | jump.
REQ-021 Branch target = ex_pc4 + (branch_offset << 2), mod 2^32.
REQ-022 Jump target = {ex_pc4[31:28], jump_index, 2'b00}.
REQ-023 When jump and br_taken are both 1, jump target wins.
REQ-024 Update priority per edge: reset > redirect > stall > !imem_ready > normal fetch.
REQ-025 On redirect: PC <= target; if_id_valid <= 0; if_id_instr <= NOP_INSTR. This overrides stall and ignores imem_ready.
REQ-026 On stall without redirect: PC, if_id_instr, if_id_pc4, if_id_valid and fetch_count all hold.
REQ-027 On !imem_ready without stall or redirect: PC holds; if_id_valid <= 0; if_id_instr <= NOP_INSTR.
REQ-028 On normal fetch: if_id_instr <= imem_rdata; if_id_pc4 <= pc4; if_id_valid <= 1; PC <= pc4; fetch_count increments by 1.
REQ-029 Latency: an instruction appears in IF/ID one cycle after imem_ready is high with its address on imem_addr.
REQ-030 Redirect penalty: exactly one bubble cycle in IF/ID.
REQ-031 PC wraps from 32'hFFFF_FFFC to 32'h0000_0000; fetch_count wraps from 32'hFFFF_FFFF to 0.
REQ-032 PC[1:0] is always 0; target bits [1:0] are forced to 0.
REQ-033 When if_id_valid=0, opcode = NOP_INSTR[31:26].

Reset
REQ-034 While reset=1 at an edge: PC <= RESET_PC; if_id_instr <= NOP_INSTR; if_id_pc4 <= RESET_PC+4; if_id_valid <= 0; fetch_count <= 0.
REQ-035 Reset overrides stall, redirect and imem_ready; a mid-operation reset discards any pending redirect.
REQ-036 Normal fetch starts at RESET_PC on the first edge after reset deasserts.

Verification
REQ-037 Reset, imem_ready=1, then 3 idle cycles -> imem_addr 0, 4, 8, C; if_id_pc4 = 4, 8, C; fetch_count = 3.
REQ-038 PC=0x10; ex_pc4=0x20, branch=1, zero=1, branch_offset=-2 for one cycle -> next PC 0x18; if_id_valid=0 for one cycle.
REQ-039 jump=1, ex_pc4=0x4000_0010, jump_index=0x40 -> PC becomes 0x4000_0100.
REQ-040 jump=1, branch=1, zero=1 together -> PC becomes the jump target.
REQ-041 stall=1 for 2 cycles, then redirect while stall=1 -> IF/ID and PC hold for 2 cycles, then redirect is taken and IF/ID is flushed.
REQ-042 imem_ready=0 for 3 cycles at PC=0x8 -> imem_addr stays 0x8; if_id_valid=0; fetch_count unchanged. Then reset asserted with stall=1 -> all REQ-034 values apply.
